uart_tx_fifo: RTL and testbench

- Byte-wide UART transmitter with a small input FIFO: the transmit-side counterpart of the transceiver's UART receiver.
- Accepts decoded bytes through a valid/ready handshake, buffers them, and serializes each as an 8N1 frame (start bit, 8 data bits LSB first, stop bit) on a single line.
- Sits after the decoder in the transceiver top and returns recovered data off-chip.

---
 rtl/uart_tx_fifo.sv | 186 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1) fed by a small circular input FIFO.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
//
// state  | meaning
// IDLE   | line high, waiting for a buffered word
// START  | start bit (low) on the line
// DATA   | data bits, LSB first
// PARITY | even-parity bit (UART_TX_PARITY_EN builds only)
// STOP   | stop bit (high); done pulses on its last cycle
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  q,
    output logic                  active,
    output logic                  done
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int NW = $clog2(DATA_WIDTH);
    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_DONE  = BW'(CLKS_PER_BIT - 2);
    localparam logic [NW-1:0] BIT_LAST   = NW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count;
    logic                  push, pop;

    state_t                state, state_nxt;
    logic [BW-1:0]         baud_cnt, baud_nxt;
    logic [NW-1:0]         bit_cnt, bit_nxt;
    logic [DATA_WIDTH-1:0] shift_reg, shift_nxt;
    logic                  q_nxt, active_nxt, done_nxt;
    logic                  baud_end;
`ifdef UART_TX_PARITY_EN
    logic                  parity_bit;
`endif

    // in_ready reflects the pre-edge count, so a full FIFO refuses a push even while popping
    assign in_ready = (count != COUNT_FULL);
    assign push     = in_valid && in_ready;
    assign baud_end = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt  = state;
        baud_nxt   = baud_end ? '0 : baud_cnt + 1'b1;
        bit_nxt    = bit_cnt;
        shift_nxt  = shift_reg;
        q_nxt      = q;
        active_nxt = active;
        done_nxt   = 1'b0;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                baud_nxt   = '0;
                q_nxt      = 1'b1;
                active_nxt = 1'b0;
                if (count != '0) begin
                    pop        = 1'b1;
                    shift_nxt  = mem[rd_ptr];
                    state_nxt  = START;
                    q_nxt      = 1'b0;
                    active_nxt = 1'b1;
                end
            end
            START: begin
                if (baud_end) begin
                    state_nxt = DATA;
                    bit_nxt   = '0;
                    q_nxt     = shift_reg[0];
                end
            end
            DATA: begin
                if (baud_end) begin
                    if (bit_cnt == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt = PARITY;
                        q_nxt     = parity_bit;
`else
                        state_nxt = STOP;
                        q_nxt     = 1'b1;
`endif
                    end else begin
                        bit_nxt   = bit_cnt + 1'b1;
                        shift_nxt = shift_reg >> 1;
                        q_nxt     = shift_reg[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_end) begin
                    state_nxt = STOP;
                    q_nxt     = 1'b1;
                end
            end
`endif
            STOP: begin
                // registered done lands on the last stop-bit cycle
                done_nxt = (baud_cnt == BAUD_DONE);
                if (baud_end) begin
                    if (count != '0) begin
                        pop        = 1'b1;
                        shift_nxt  = mem[rd_ptr];
                        state_nxt  = START;
                        q_nxt      = 1'b0;
                        active_nxt = 1'b1;
                    end else begin
                        state_nxt  = IDLE;
                        q_nxt      = 1'b1;
                        active_nxt = 1'b0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            q         <= 1'b1;
            active    <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            baud_cnt  <= baud_nxt;
            bit_cnt   <= bit_nxt;
            shift_reg <= shift_nxt;
            q         <= q_nxt;
            active    <= active_nxt;
            done      <= done_nxt;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   parity_bit <= 1'b0;
        else if (pop) parity_bit <= ^mem[rd_ptr];
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed and random pushes checked cycle by cycle against a
// frame-level model (queue of pending bytes plus position within the current frame).
module tb_uart_tx_fifo;

    localparam int C     = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FL = 11 * C;
`else
    localparam int FL = 10 * C;
`endif

    logic       clk, rst_n;
    logic [7:0] in_data;
    logic       in_valid, in_ready, q, active, done;

    int errors = 0;
    int checks = 0;

    logic [7:0] pend[$];
    logic [7:0] cur;
    bit         busy;
    int         t;
    bit         accepted;

    uart_tx_fifo #(.CLKS_PER_BIT(C), .DATA_WIDTH(8), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .q        (q),
        .active   (active),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b at %0t", name, obs, exp, $time);
        end
    endtask

    // bit idx of a frame: start, 8 data bits LSB first, optional parity, stop
    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic model_reset();
        pend.delete();
        busy     = 1'b0;
        t        = 0;
        accepted = 1'b0;
    endtask

    task automatic model_edge(input logic v, input logic [7:0] d);
        int  pre;
        bit  ending;
        pre      = pend.size();
        ending   = busy && (t == FL - 1);
        accepted = 1'b0;
        if (busy && !ending) begin
            t++;
        end else if (pre > 0) begin
            cur  = pend.pop_front();
            t    = 0;
            busy = 1'b1;
        end else begin
            busy = 1'b0;
        end
        if (v && pre != DEPTH) begin
            pend.push_back(d);
            accepted = 1'b1;
        end
    endtask

    task automatic check_outputs();
        chk("q",        q,        busy ? frame_bit(cur, t / C) : 1'b1);
        chk("active",   active,   busy);
        chk("done",     done,     busy && (t == FL - 1));
        chk("in_ready", in_ready, pend.size() != DEPTH);
    endtask

    task automatic step(input logic v, input logic [7:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        model_edge(v, d);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drain();
        int n = 0;
        while ((busy || pend.size() != 0) && n < 3000) begin
            step(1'b0, 8'($urandom));
            n++;
        end
        chk("drain_timeout", busy || (pend.size() != 0), 1'b0);
    endtask

    initial begin
        int n;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_q",        q,        1'b1);
        chk("rst_active",   active,   1'b0);
        chk("rst_done",     done,     1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;

        // idle hold
        repeat (100) step(1'b0, 8'($urandom));

        // single byte
        step(1'b1, 8'hA5);
        drain();

        // back-to-back frames
        step(1'b1, 8'h00);
        step(1'b1, 8'hFF);
        drain();

        // fill the FIFO, then hold the sixth word until it is taken
        for (int k = 1; k <= 5; k++) step(1'b1, 8'(k));
        chk("full_refuse", accepted, 1'b1);
        n = 0;
        do begin
            step(1'b1, 8'h06);
            n++;
        end while (!accepted && n < 200);
        chk("full_accept_timeout", accepted, 1'b1);
        drain();

        // parity-sensitive bytes
        step(1'b1, 8'h07);
        drain();
        step(1'b1, 8'h03);
        drain();

        // random traffic
        repeat (500) step(1'($urandom_range(0, 1)), 8'($urandom));
        drain();

        // reset during the third data bit, with a second word still buffered
        step(1'b1, 8'h5A);
        step(1'b1, 8'h33);
        n = 0;
        while (!(busy && t == 3 * C + 1) && n < 100) begin
            step(1'b0, 8'h00);
            n++;
        end
        chk("midreset_wait_timeout", busy && (t == 3 * C + 1), 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_q",        q,        1'b1);
        chk("midrst_active",   active,   1'b0);
        chk("midrst_done",     done,     1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) step(1'b0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
